axi_bus_sampler: RTL

- Consumer of the 16-bit sample configuration control word.
- Passively monitors the AXI4-lite side of the AXI4-lite-to-APB4 bridge.
- Qualifies each channel handshake by channel type and protection class against the control word.
- Captures qualifying events into per-channel holding slots, drains them into a FIFO, and presents the FIFO head for software pop via the register block.

---
 rtl/sampler_pkg.sv | 24 ++
 rtl/sampler_fifo.sv | 47 ++++
 rtl/axi_bus_sampler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sampler_pkg.sv
// Shared types and helpers for the AXI4-lite bus sampler.
package sampler_pkg;

    localparam logic [1:0] TYPE_WADDR = 2'd3;
    localparam logic [1:0] TYPE_WDATA = 2'd2;
    localparam logic [1:0] TYPE_RADDR = 2'd1;
    localparam logic [1:0] TYPE_RDATA = 2'd0;

    typedef struct packed {
        logic [1:0]  etype;
        logic [1:0]  eclass;
        logic [31:0] value;
    } entry_t;

    function automatic logic [1:0] class_of(input logic [2:0] prot);
        return {prot[0], prot[2]};
    endfunction

    // Bit (type*4 + 3 - class) of the control word; 3 - class is ~class for 2 bits.
    function automatic logic [3:0] ctrl_index(input logic [1:0] etype, input logic [1:0] eclass);
        return {etype, ~eclass};
    endfunction

endpackage

// File: rtl/sampler_fifo.sv
// Synchronous FIFO of captured entries with combinational head output.
module sampler_fifo
    import sampler_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_pop;
    logic          do_push;

    assign count   = wptr - rptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axi_bus_sampler.sv
// Passive AXI4-lite monitor: qualifies handshakes against the control word,
// parks them in per-type slots and drains one slot per cycle into a FIFO.
module axi_bus_sampler
    import sampler_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [15:0]              sample_conf_ctrl,
    input  logic                     awvalid,
    input  logic                     awready,
    input  logic [31:0]              awaddr,
    input  logic [2:0]               awprot,
    input  logic                     wvalid,
    input  logic                     wready,
    input  logic [31:0]              wdata,
    input  logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              araddr,
    input  logic [2:0]               arprot,
    input  logic                     rvalid,
    input  logic                     rready,
    input  logic [31:0]              rdata,
    input  logic                     pop,
    input  logic                     clr_drop,
    output logic [31:0]              head_value,
    output logic [3:0]               head_tag,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     empty,
    output logic [DROP_W-1:0]        drop_cnt
);

    logic [2:0]        aw_prot_q;
    logic [2:0]        ar_prot_q;
    logic [3:0]        ev;
    logic [3:0][31:0]  ev_value;
    logic [3:0][1:0]   ev_class;
    logic [3:0]        qual;
    logic [3:0]        drop_vec;
    logic [2:0]        drop_num;
    logic [DROP_W:0]   drop_sum;

    logic [3:0]        slot_valid;
    logic [3:0][31:0]  slot_value;
    logic [3:0][1:0]   slot_class;

    logic              drain_valid;
    logic [1:0]        drain_sel;
    logic              push;
    entry_t            push_entry;
    entry_t            head;
    logic              fifo_full;

    always_comb begin
        ev       = '0;
        ev_value = '0;
        ev_class = '0;
        ev[TYPE_WADDR]       = awvalid & awready;
        ev[TYPE_WDATA]       = wvalid & wready;
        ev[TYPE_RADDR]       = arvalid & arready;
        ev[TYPE_RDATA]       = rvalid & rready;
        ev_value[TYPE_WADDR] = awaddr;
        ev_value[TYPE_WDATA] = wdata;
        ev_value[TYPE_RADDR] = araddr;
        ev_value[TYPE_RDATA] = rdata;
        ev_class[TYPE_WADDR] = class_of(awprot);
        ev_class[TYPE_RADDR] = class_of(arprot);
        // Data beats inherit protection from a same-cycle address handshake if there is one.
        ev_class[TYPE_WDATA] = class_of(ev[TYPE_WADDR] ? awprot : aw_prot_q);
        ev_class[TYPE_RDATA] = class_of(ev[TYPE_RADDR] ? arprot : ar_prot_q);
    end

    always_comb begin
        qual     = '0;
        drop_vec = '0;
        drop_num = '0;
        for (int t = 0; t < 4; t++) begin
            qual[t]     = ev[t] & sample_conf_ctrl[ctrl_index(2'(t), ev_class[t])];
            drop_vec[t] = qual[t] & slot_valid[t];
            drop_num    = drop_num + {2'b00, drop_vec[t]};
        end
    end

    // Ascending scan so the highest type code (WADDR) wins the drain.
    always_comb begin
        drain_valid = 1'b0;
        drain_sel   = TYPE_RDATA;
        for (int t = 0; t < 4; t++) begin
            if (slot_valid[t]) begin
                drain_valid = 1'b1;
                drain_sel   = 2'(t);
            end
        end
    end

    assign push       = drain_valid && (!fifo_full || (pop && !empty));
    assign push_entry = '{etype: drain_sel, eclass: slot_class[drain_sel], value: slot_value[drain_sel]};
    assign drop_sum   = {1'b0, drop_cnt} + (DROP_W+1)'(drop_num);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_prot_q  <= '0;
            ar_prot_q  <= '0;
            slot_valid <= '0;
            slot_value <= '0;
            slot_class <= '0;
            drop_cnt   <= '0;
        end else begin
            if (ev[TYPE_WADDR]) aw_prot_q <= awprot;
            if (ev[TYPE_RADDR]) ar_prot_q <= arprot;
            for (int t = 0; t < 4; t++) begin
                if (push && (drain_sel == 2'(t))) begin
                    slot_valid[t] <= 1'b0;
                end else if (qual[t] && !slot_valid[t]) begin
                    slot_valid[t] <= 1'b1;
                    slot_value[t] <= ev_value[t];
                    slot_class[t] <= ev_class[t];
                end
            end
            if (clr_drop)
                drop_cnt <= DROP_W'(drop_num);
            else if (drop_sum[DROP_W])
                drop_cnt <= '1;
            else
                drop_cnt <= drop_sum[DROP_W-1:0];
        end
    end

    sampler_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign head_value = head.value;
    assign head_tag   = {head.etype, head.eclass};

endmodule
